// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: fetches from the I-cache, hands each word to the decoder,
// pushes formalized instructions into the IQ, and handles ROB redirects and JALR stalls.
module inst_fetch_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        _icache_req,
    output logic [31:0] _icache_addr,
    input  logic        _icache_ready,
    input  logic [31:0] _icache_data,
    output logic [31:0] _dec_inst,
    output logic        _dec_inst_valid,
    output logic [31:0] _dec_inst_addr,
    input  logic [31:0] _dec_next_pc,
    input  logic        _dec_stall,
    input  logic [31:0] _dec_formalized,
    input  logic        _dec_rvc,
    input  logic        _br_rob,
    input  logic        _iq_full,
    output logic        _iq_push,
    output logic [31:0] _iq_inst,
    output logic [31:0] _iq_pc,
    output logic        _iq_rvc
);

    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_DECODE    = 2'd1,
        S_WAIT_JALR = 2'd2,
        S_DRAIN     = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst_buf;
    logic [31:0] r_drain_addr;

    logic [31:0] w_redirect_pc;
    logic        w_push;

    // Bit 0 is dropped so the PC stays halfword aligned whatever the decoder drives.
    assign w_redirect_pc = _dec_next_pc & 32'hFFFF_FFFE;

    assign w_push = rdy_in && !rst_in && !_br_rob && !_iq_full && (r_state == S_DECODE);

    assign _icache_req     = (r_state == S_FETCH) || (r_state == S_DRAIN);
    // While draining, the cache still owes a response for the old address.
    assign _icache_addr    = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
    assign _dec_inst       = r_inst_buf;
    assign _dec_inst_addr  = r_pc;
    assign _dec_inst_valid = (r_state == S_DECODE);

    assign _iq_push = w_push;
    assign _iq_inst = _dec_formalized;
    assign _iq_pc   = r_pc;
    assign _iq_rvc  = _dec_rvc;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= S_FETCH;
            r_pc         <= 32'h0000_0000;
            r_inst_buf   <= 32'h0000_0000;
            r_drain_addr <= 32'h0000_0000;
        end else if (rdy_in) begin
            if (_br_rob) begin
                r_pc <= w_redirect_pc;
                case (r_state)
                    S_FETCH: begin
                        if (!_icache_ready) begin
                            r_state      <= S_DRAIN;
                            r_drain_addr <= r_pc;
                        end
                    end
                    S_DRAIN: begin
                        if (_icache_ready) begin
                            r_state <= S_FETCH;
                        end
                    end
                    default: r_state <= S_FETCH;
                endcase
            end else begin
                case (r_state)
                    S_FETCH: begin
                        if (_icache_ready) begin
                            r_inst_buf <= _icache_data;
                            r_state    <= S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        if (!_iq_full) begin
                            if (_dec_stall) begin
                                r_state <= S_WAIT_JALR;
                            end else begin
                                r_pc    <= w_redirect_pc;
                                r_state <= S_FETCH;
                            end
                        end
                    end
                    S_WAIT_JALR: r_state <= S_WAIT_JALR;
                    S_DRAIN: begin
                        if (_icache_ready) begin
                            r_state <= S_FETCH;
                        end
                    end
                    default: r_state <= S_FETCH;
                endcase
            end
        end
    end

endmodule
